// File: rtl/date_pkg.sv
// Shared definitions for the calendar date counter.
//   - month constants JAN..DEC
//   - month lengths (31/30 days, February 28/29)
//   - manual edit select encoding
//   - bin_to_bcd: split a binary value 0..31 into BCD tens/ones
package date_pkg;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  localparam logic [4:0] DAYS_31       = 5'd31;
  localparam logic [4:0] DAYS_30       = 5'd30;
  localparam logic [4:0] FEB_DAYS      = 5'd28;
  localparam logic [4:0] FEB_LEAP_DAYS = 5'd29;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_DAY   = 2'b01;
  localparam logic [1:0] SEL_MONTH = 2'b10;

  // Returns {tens, ones}; valid for inputs 0..31 (tens never exceeds 3).
  function automatic logic [7:0] bin_to_bcd(input logic [4:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 5'd30) begin
      tens = 4'd3;
      ones = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(v - 5'd10);
    end else begin
      tens = 4'd0;
      ones = v[3:0];
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/date_counter_leap_year_detect.sv
// Gregorian leap-year detector (combinational).
//   year_bin : year offset from BASE_YEAR (0..999)
//   leap     : 1 when BASE_YEAR + year_bin is a leap year
module leap_year_detect #(
  parameter int BASE_YEAR = 2000
) (
  input  logic [10:0] year_bin,
  output logic        leap
);

  logic [11:0] year;

  assign year = 12'(BASE_YEAR) + {1'b0, year_bin};

  assign leap = (((year % 12'd4) == 12'd0) && ((year % 12'd100) != 12'd0)) ||
                ((year % 12'd400) == 12'd0);

endmodule

// File: rtl/date_counter.sv
// Day-of-month / month counter with manual editing.
//   clk, rst_n      : clock, asynchronous active-low reset
//   day_en          : one-cycle pulse, advance one day
//   sel, incr, dcr  : manual edit (sel 01 day, 10 month); incr/dcr one-cycle pulses
//   year_bin        : current year offset from the year counter
//   day_*/month_*   : BCD digits of the registered day and month
//   year_en         : registered one-cycle pulse on the 31 Dec -> 01 Jan rollover
module date_counter
  import date_pkg::*;
#(
  parameter int BASE_YEAR = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        day_en,
  input  logic [1:0]  sel,
  input  logic        incr,
  input  logic        dcr,
  input  logic [10:0] year_bin,
  output logic [3:0]  day_ones,
  output logic [3:0]  day_tens,
  output logic [3:0]  month_ones,
  output logic [3:0]  month_tens,
  output logic        year_en
);

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic lp);
    logic [4:0] n;
    case (m)
      FEB:                n = lp ? FEB_LEAP_DAYS : FEB_DAYS;
      APR, JUN, SEP, NOV: n = DAYS_30;
      default:            n = DAYS_31;
    endcase
    return n;
  endfunction

  logic [4:0] day;
  logic [3:0] month;
  logic [4:0] day_next;
  logic [3:0] month_next;
  logic       year_en_next;
  logic       leap;
  logic [4:0] dim_cur;
  logic [3:0] month_edit;
  logic [4:0] dim_edit;
  logic       manual;

  leap_year_detect #(
    .BASE_YEAR (BASE_YEAR)
  ) u_leap (
    .year_bin (year_bin),
    .leap     (leap)
  );

  assign dim_cur = days_in_month(month, leap);
  assign manual  = incr ^ dcr;

  // Candidate month for a manual month edit, and its length for the day clamp.
  always_comb begin
    month_edit = month;
    if (incr) begin
      month_edit = (month >= DEC) ? JAN : month + 4'd1;
    end else begin
      month_edit = (month <= JAN) ? DEC : month - 4'd1;
    end
  end

  assign dim_edit = days_in_month(month_edit, leap);

  always_comb begin
    day_next     = day;
    month_next   = month;
    year_en_next = 1'b0;
    if (day_en) begin
      if (day < dim_cur) begin
        day_next = day + 5'd1;
      end else begin
        day_next = 5'd1;
        if (month < DEC) begin
          month_next = month + 4'd1;
        end else begin
          month_next   = JAN;
          year_en_next = 1'b1;
        end
      end
    end else if (manual && (sel == SEL_DAY)) begin
      // A day beyond the month end (leap -> non-leap change) is treated as
      // the last day of the month for the wrap decision.
      if (incr) begin
        day_next = (day >= dim_cur) ? 5'd1 : day + 5'd1;
      end else if (day <= 5'd1) begin
        day_next = dim_cur;
      end else if (day > dim_cur) begin
        day_next = dim_cur - 5'd1;
      end else begin
        day_next = day - 5'd1;
      end
    end else if (manual && (sel == SEL_MONTH)) begin
      month_next = month_edit;
      day_next   = (day > dim_edit) ? dim_edit : day;
    end else if (day > dim_cur) begin
      day_next = dim_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day     <= 5'd1;
      month   <= JAN;
      year_en <= 1'b0;
    end else begin
      day     <= day_next;
      month   <= month_next;
      year_en <= year_en_next;
    end
  end

  assign {day_tens, day_ones}     = bin_to_bcd(day);
  assign {month_tens, month_ones} = bin_to_bcd({1'b0, month});

endmodule

// File: tb/tb_date_counter.sv
// Randomised and directed bench for date_counter against a calendar model.
module tb_date_counter;

  logic        clk;
  logic        rst_n;
  logic        day_en;
  logic [1:0]  sel;
  logic        incr;
  logic        dcr;
  logic [10:0] year_bin;
  logic [3:0]  day_ones;
  logic [3:0]  day_tens;
  logic [3:0]  month_ones;
  logic [3:0]  month_tens;
  logic        year_en;

  int checks;
  int failures;

  int m_day;
  int m_month;
  int m_yen;

  date_counter #(
    .BASE_YEAR (2000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .day_en     (day_en),
    .sel        (sel),
    .incr       (incr),
    .dcr        (dcr),
    .year_bin   (year_bin),
    .day_ones   (day_ones),
    .day_tens   (day_tens),
    .month_ones (month_ones),
    .month_tens (month_tens),
    .year_en    (year_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dim_f(int m, int yb);
    int  y;
    bit  lp;
    y  = 2000 + yb;
    lp = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (m == 2) return lp ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Next calendar state encoded as day + 100*month + 10000*year_en.
  function automatic int model_next(int d, int m, int yb, bit de, bit inc, bit dc, int s);
    int dm;
    int nd;
    int nm;
    int ny;
    int eff;
    dm = dim_f(m, yb);
    nd = d;
    nm = m;
    ny = 0;
    if (de) begin
      if (d < dm) nd = d + 1;
      else begin
        nd = 1;
        if (m < 12) nm = m + 1;
        else begin
          nm = 1;
          ny = 1;
        end
      end
    end else if (inc != dc && s == 1) begin
      eff = (d > dm) ? dm : d;
      if (inc) nd = (eff == dm) ? 1 : eff + 1;
      else     nd = (eff == 1) ? dm : eff - 1;
    end else if (inc != dc && s == 2) begin
      if (inc) nm = (m == 12) ? 1 : m + 1;
      else     nm = (m == 1) ? 12 : m - 1;
      if (d > dim_f(nm, yb)) nd = dim_f(nm, yb);
    end else if (d > dm) begin
      nd = dm;
    end
    return nd + 100 * nm + 10000 * ny;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_day   <= 1;
      m_month <= 1;
      m_yen   <= 0;
    end else begin
      m_day   <= model_next(m_day, m_month, int'(year_bin), day_en, incr, dcr, int'(sel)) % 100;
      m_month <= (model_next(m_day, m_month, int'(year_bin), day_en, incr, dcr, int'(sel)) / 100) % 100;
      m_yen   <= model_next(m_day, m_month, int'(year_bin), day_en, incr, dcr, int'(sel)) / 10000;
    end
  end

  function automatic int dut_day();
    return int'(day_tens) * 10 + int'(day_ones);
  endfunction

  function automatic int dut_month();
    return int'(month_tens) * 10 + int'(month_ones);
  endfunction

  task automatic compare_model();
    checks++;
    if (int'(day_tens) != m_day / 10 || int'(day_ones) != m_day % 10 ||
        int'(month_tens) != m_month / 10 || int'(month_ones) != m_month % 10 ||
        int'(year_en) != m_yen) begin
      failures++;
      $display("FAIL model t=%0t got day=%0d%0d month=%0d%0d yen=%0d expected day=%0d month=%0d yen=%0d",
               $time, day_tens, day_ones, month_tens, month_ones, year_en, m_day, m_month, m_yen);
    end
  endtask

  task automatic check_lit(input string name, input int d, input int m, input int y);
    checks++;
    if (dut_day() != d || dut_month() != m || int'(year_en) != y) begin
      failures++;
      $display("FAIL %s got %0d/%0d yen=%0d expected %0d/%0d yen=%0d",
               name, dut_day(), dut_month(), year_en, d, m, y);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
  endtask

  task automatic pulse(input bit de, input bit inc, input bit dc, input logic [1:0] s);
    day_en = de;
    incr   = inc;
    dcr    = dc;
    sel    = s;
    tick();
    day_en = 1'b0;
    incr   = 1'b0;
    dcr    = 1'b0;
    sel    = 2'b00;
  endtask

  task automatic set_date(input int d, input int m);
    for (int i = 0; i < 12 && m_month != m; i++) pulse(1'b0, 1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 32 && m_day != d; i++) pulse(1'b0, 1'b1, 1'b0, 2'b01);
  endtask

  int pick;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    day_en   = 1'b0;
    sel      = 2'b00;
    incr     = 1'b0;
    dcr      = 1'b0;
    year_bin = 11'd0;
    tick();
    tick();
    check_lit("reset", 1, 1, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_lit("hold_after_reset", 1, 1, 0);

    // Reset in the middle of counting.
    for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0, 1'b0, 2'b00);
    check_lit("count_to_10", 10, 1, 0);
    #2 rst_n = 1'b0;
    #1 check_lit("async_reset", 1, 1, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_lit("hold_after_release", 1, 1, 0);

    // Leap February 2024.
    year_bin = 11'd24;
    set_date(28, 2);
    check_lit("set_28_02", 28, 2, 0);
    pulse(1'b1, 1'b0, 1'b0, 2'b00);
    check_lit("leap_29_02", 29, 2, 0);
    pulse(1'b1, 1'b0, 1'b0, 2'b00);
    check_lit("leap_01_03", 1, 3, 0);

    // Century years.
    year_bin = 11'd100;
    set_date(28, 2);
    pulse(1'b1, 1'b0, 1'b0, 2'b00);
    check_lit("y2100_01_03", 1, 3, 0);
    year_bin = 11'd400;
    set_date(28, 2);
    pulse(1'b1, 1'b0, 1'b0, 2'b00);
    check_lit("y2400_29_02", 29, 2, 0);

    // Year rollover with the bench acting as year counter.
    year_bin = 11'd5;
    set_date(31, 12);
    check_lit("set_31_12", 31, 12, 0);
    pulse(1'b1, 1'b0, 1'b0, 2'b00);
    check_lit("rollover_pulse", 1, 1, 1);
    if (year_en) year_bin = year_bin + 11'd1;
    tick();
    check_lit("rollover_pulse_end", 1, 1, 0);
    checks++;
    if (year_bin != 11'd6) begin
      failures++;
      $display("FAIL year_counter got %0d expected 6", year_bin);
    end

    // Manual month clamp and wraps.
    year_bin = 11'd1;
    set_date(31, 1);
    check_lit("set_31_01", 31, 1, 0);
    pulse(1'b0, 1'b1, 1'b0, 2'b10);
    check_lit("month_clamp", 28, 2, 0);
    set_date(1, 1);
    pulse(1'b0, 1'b0, 1'b1, 2'b10);
    check_lit("month_dcr_wrap", 1, 12, 0);
    set_date(30, 4);
    pulse(1'b0, 1'b1, 1'b0, 2'b01);
    check_lit("day_incr_wrap", 1, 4, 0);
    pulse(1'b0, 1'b0, 1'b1, 2'b01);
    check_lit("day_dcr_wrap", 30, 4, 0);
    pulse(1'b0, 1'b1, 1'b1, 2'b01);
    check_lit("incr_and_dcr", 30, 4, 0);
    pulse(1'b0, 1'b1, 1'b0, 2'b11);
    check_lit("sel_11", 30, 4, 0);

    // Collision and leap clamp.
    set_date(15, 6);
    pulse(1'b1, 1'b1, 1'b0, 2'b01);
    check_lit("collision", 16, 6, 0);
    year_bin = 11'd0;
    set_date(29, 2);
    check_lit("set_29_02_2000", 29, 2, 0);
    year_bin = 11'd1;
    tick();
    check_lit("leap_clamp", 28, 2, 0);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        pick = int'($urandom_range(0, 5));
        case (pick)
          0: year_bin = 11'd0;
          1: year_bin = 11'd1;
          2: year_bin = 11'd24;
          3: year_bin = 11'd100;
          4: year_bin = 11'd400;
          default: year_bin = 11'($urandom_range(0, 999));
        endcase
      end
      day_en = ($urandom_range(0, 3) == 0);
      incr   = 1'($urandom_range(0, 1));
      dcr    = 1'($urandom_range(0, 1));
      sel    = 2'($urandom_range(0, 3));
      tick();
    end
    day_en = 1'b0;
    incr   = 1'b0;
    dcr    = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
Day-of-month and month counter for the digital clock/calendar. It sits directly upstream of the year counter and consumes the day-rollover pulse from the time-of-day chain. It produces a single-cycle year_en pulse on the 31 Dec -> 01 Jan rollover, and BCD day and month digits for the display. It reads year_bin back from the year counter so that February length follows the Gregorian leap rule.

Parameters:
BASE_YEAR, 2000, calendar year represented by year_bin = 0; actual year = BASE_YEAR + year_bin.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst_n  input  1  asynchronous reset, active-low
day_en  input  1  one-cycle pulse, advance one day (from the hour-counter rollover)
sel  input  2  manual edit target: 00 none, 01 day, 10 month, 11 none
incr  input  1  one-cycle pulse, manual +1 on the selected field
dcr  input  1  one-cycle pulse, manual -1 on the selected field
year_bin  input  11  current year offset from the year counter, range 0..999
day_ones  output  4  BCD units of day, 0..9
day_tens  output  4  BCD tens of day, 0..3
month_ones  output  4  BCD units of month, 0..9
month_tens  output  4  BCD tens of month, 0..1
year_en  output  1  registered one-cycle pulse on the year rollover

Behaviour:
- Reset (async, rst_n low): day = 01, month = 01 (day_tens 0, day_ones 1, month_tens 0, month_ones 1), year_en = 0. Reset mid-operation aborts any update immediately.
- Internal state is binary day 1..31 and month 1..12. BCD outputs are registered, or are a pure function of the registered state with no extra latency. Outputs reflect an update in the cycle after the triggering edge.
- days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; for month 2, 29 if leap else 28.
- leap: Y = BASE_YEAR + year_bin (12-bit). Leap when (Y mod 4 == 0 and Y mod 100 != 0) or Y mod 400 == 0.
- Update priority per cycle, highest first:
  1. day_en = 1: if day < days_in_month, day+1. Otherwise day = 1, then: if month < 12, month+1; else month = 1 and year_en = 1 in the next cycle. incr and dcr are ignored this cycle.
  2. incr XOR dcr with sel = 01: day +/-1, wrapping within the current month (max -> 1 on incr, 1 -> max on dcr). Never asserts year_en.
  3. incr XOR dcr with sel = 10: month +/-1, wrapping 12 -> 1 and 1 -> 12. No year_en. In the same update, day = min(day, days_in_month(new month)).
  4. Otherwise, if day > days_in_month (for example, the year changed from leap to non-leap while on 29 Feb), day = days_in_month on that edge.
  5. Otherwise hold.
- incr and dcr high together: no manual change.
- sel = 00 or 11 with incr/dcr: no change.
- year_en is high for exactly one clk cycle and low otherwise; it is never asserted by a manual edit.
- Day and month never leave their legal ranges under any input sequence.

Decomposition:
- Shared package date_pkg:
  - month constants JAN..DEC (4-bit).
  - DAYS_31 / DAYS_30 month constants and the 28/29 February lengths.
  - sel encoding constants SEL_NONE, SEL_DAY, SEL_MONTH.
- Sub-module leap_year_detect: combinational, inputs year_bin and BASE_YEAR, output leap. It is reusable by the year-setting logic.
- Binary-to-BCD split (values 0..31) is an inline function in date_pkg.

Test Plan:
- Reset: assert rst_n low mid-count -> outputs immediately 01/01 with year_en = 0; after release, hold with no stimulus.
- Leap February: year_bin = 24 (2024), set 28/02, pulse day_en -> 29/02; pulse again -> 01/03; year_en stays 0.
- Century non-leap: year_bin = 100 (2100), 28/02 + day_en -> 01/03. year_bin = 400 (2400), 28/02 + day_en -> 29/02.
- Year rollover: 31/12 + day_en -> 01/01 and year_en = 1 for exactly one cycle after the edge. Connect a year counter and check year_bin 5 -> 6.
- Manual month clamp: year_bin = 1 (2001), 31/01, sel = 10 with incr -> 28/02. dcr from 01 -> month 12 with no year_en. Day incr at 30/04 -> 01/04.
- Collision and clamp:
  - day_en and incr together at 15/06 with sel = 01 -> 16/06 only.
  - At 29/02/2000, change year_bin to 1 -> day becomes 28 on the next edge.
